// File: rtl/pcie_ts_os_gen.sv
// PCIe TS1/TS2 ordered-set generator: emits 16-symbol training sets with valid/ready handshake.
// Optional completed-set counter is enabled by defining PCIE_TS_OS_CNT_EN.
module pcie_ts_os_gen #(
  parameter int OS_CNT_W = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic                ts2_i,
  input  logic                link_pad_i,
  input  logic                lane_pad_i,
  input  logic [7:0]          link_num_i,
  input  logic [4:0]          lane_num_i,
  input  logic [7:0]          n_fts_i,
  input  logic [7:0]          rate_id_i,
  input  logic [7:0]          train_ctrl_i,
  input  logic                sym_ready_i,
  output logic                sym_valid_o,
  output logic [7:0]          sym_data_o,
  output logic                sym_k_o,
  output logic                sos_o,
  output logic                eos_o,
  output logic                busy_o,
  output logic [OS_CNT_W-1:0] os_cnt_o
);

  typedef enum logic {IDLE, SEND} state_t;

  typedef struct packed {
    logic       ts2;
    logic       link_pad;
    logic       lane_pad;
    logic [7:0] link_num;
    logic [4:0] lane_num;
    logic [7:0] n_fts;
    logic [7:0] rate_id;
    logic [7:0] train_ctrl;
  } snap_t;

  localparam logic [7:0] SYM_COM = 8'hBC;
  localparam logic [7:0] SYM_PAD = 8'hF7;
  localparam logic [7:0] SYM_TS1 = 8'h4A;
  localparam logic [7:0] SYM_TS2 = 8'h45;

  state_t      state_reg, state_next;
  logic [3:0]  idx_reg, idx_next;
  snap_t       snap_reg, snap_next, snap_in;
  logic        valid_reg, k_reg, sos_reg, eos_reg, busy_reg;
  logic [7:0]  data_reg;
  logic        valid_next, k_next, sos_next, eos_next, busy_next;
  logic [7:0]  data_next;
  logic        accept;

  assign snap_in = '{ts2: ts2_i, link_pad: link_pad_i, lane_pad: lane_pad_i,
                     link_num: link_num_i, lane_num: lane_num_i, n_fts: n_fts_i,
                     rate_id: rate_id_i, train_ctrl: train_ctrl_i};

  // valid_reg is high exactly while in SEND, so it doubles as the handshake qualifier
  assign accept = valid_reg & sym_ready_i;

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    snap_next  = snap_reg;
    case (state_reg)
      IDLE: begin
        if (en_i) begin
          snap_next  = snap_in;
          idx_next   = 4'd0;
          state_next = SEND;
        end
      end
      SEND: begin
        if (accept) begin
          if (idx_reg == 4'd15) begin
            idx_next = 4'd0;
            if (en_i) begin
              snap_next = snap_in;
            end else begin
              state_next = IDLE;
            end
          end else begin
            idx_next = idx_reg + 4'd1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = 4'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered symbol lines up with the index
  always_comb begin
    k_next    = 1'b0;
    data_next = 8'h00;
    case (idx_next)
      4'd0: begin
        k_next    = 1'b1;
        data_next = SYM_COM;
      end
      4'd1: begin
        k_next    = snap_next.link_pad;
        data_next = snap_next.link_pad ? SYM_PAD : snap_next.link_num;
      end
      4'd2: begin
        k_next    = snap_next.lane_pad;
        data_next = snap_next.lane_pad ? SYM_PAD : {3'b000, snap_next.lane_num};
      end
      4'd3:    data_next = snap_next.n_fts;
      4'd4:    data_next = snap_next.rate_id;
      4'd5:    data_next = snap_next.train_ctrl;
      default: data_next = snap_next.ts2 ? SYM_TS2 : SYM_TS1;
    endcase
    valid_next = (state_next == SEND);
    busy_next  = valid_next;
    sos_next   = valid_next && (idx_next == 4'd0);
    eos_next   = valid_next && (idx_next == 4'd15);
    if (!valid_next) begin
      k_next    = 1'b0;
      data_next = 8'h00;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
      idx_reg   <= 4'd0;
      snap_reg  <= '0;
      valid_reg <= 1'b0;
      data_reg  <= 8'h00;
      k_reg     <= 1'b0;
      sos_reg   <= 1'b0;
      eos_reg   <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      snap_reg  <= snap_next;
      valid_reg <= valid_next;
      data_reg  <= data_next;
      k_reg     <= k_next;
      sos_reg   <= sos_next;
      eos_reg   <= eos_next;
      busy_reg  <= busy_next;
    end
  end

  assign sym_valid_o = valid_reg;
  assign sym_data_o  = data_reg;
  assign sym_k_o     = k_reg;
  assign sos_o       = sos_reg;
  assign eos_o       = eos_reg;
  assign busy_o      = busy_reg;

`ifdef PCIE_TS_OS_CNT_EN
  logic [OS_CNT_W-1:0] os_cnt_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      os_cnt_reg <= '0;
    end else if (accept && (idx_reg == 4'd15) && (os_cnt_reg != '1)) begin
      os_cnt_reg <= os_cnt_reg + OS_CNT_W'(1);
    end
  end

  assign os_cnt_o = os_cnt_reg;
`else
  assign os_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pcie_ts_os_gen.sv
// Self-checking bench for pcie_ts_os_gen: directed scenarios plus randomized traffic
// against a set-level reference model.
module tb_pcie_ts_os_gen;

  localparam int CW      = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          en_i = 1'b0, ts2_i = 1'b0, link_pad_i = 1'b0, lane_pad_i = 1'b0;
  logic [7:0]    link_num_i = 8'h00, n_fts_i = 8'h00, rate_id_i = 8'h00, train_ctrl_i = 8'h00;
  logic [4:0]    lane_num_i = 5'h00;
  logic          sym_ready_i = 1'b1;
  logic          sym_valid_o, sym_k_o, sos_o, eos_o, busy_o;
  logic [7:0]    sym_data_o;
  logic [CW-1:0] os_cnt_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  pcie_ts_os_gen #(.OS_CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .ts2_i(ts2_i),
    .link_pad_i(link_pad_i), .lane_pad_i(lane_pad_i), .link_num_i(link_num_i),
    .lane_num_i(lane_num_i), .n_fts_i(n_fts_i), .rate_id_i(rate_id_i),
    .train_ctrl_i(train_ctrl_i), .sym_ready_i(sym_ready_i), .sym_valid_o(sym_valid_o),
    .sym_data_o(sym_data_o), .sym_k_o(sym_k_o), .sos_o(sos_o), .eos_o(eos_o),
    .busy_o(busy_o), .os_cnt_o(os_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: a whole set is built from the inputs when one starts, then
  // walked one symbol per accepted handshake.
  logic [8:0] m_set [16];
  bit         m_valid = 1'b0;
  int         m_pos = 0;
  int         m_cnt = 0;

  function automatic logic [8:0] sym_kd(input bit k, input logic [7:0] d);
    return {k, d};
  endfunction

  task automatic build_set();
    m_set[0] = sym_kd(1'b1, 8'hBC);
    m_set[1] = link_pad_i ? sym_kd(1'b1, 8'hF7) : sym_kd(1'b0, link_num_i);
    m_set[2] = lane_pad_i ? sym_kd(1'b1, 8'hF7) : sym_kd(1'b0, {3'b000, lane_num_i});
    m_set[3] = sym_kd(1'b0, n_fts_i);
    m_set[4] = sym_kd(1'b0, rate_id_i);
    m_set[5] = sym_kd(1'b0, train_ctrl_i);
    for (int i = 6; i < 16; i++) m_set[i] = sym_kd(1'b0, ts2_i ? 8'h45 : 8'h4A);
  endtask

  task automatic model_edge();
    cyc++;
    if (!rst_ni) begin
      m_valid = 1'b0; m_pos = 0; m_cnt = 0;
      return;
    end
    if (!m_valid) begin
      if (en_i) begin build_set(); m_pos = 0; m_valid = 1'b1; end
    end else if (sym_ready_i) begin
      if (m_pos == 15) begin
`ifdef PCIE_TS_OS_CNT_EN
        if (m_cnt < CNT_MAX) m_cnt++;
`endif
        m_pos = 0;
        if (en_i) build_set();
        else m_valid = 1'b0;
      end else begin
        m_pos++;
      end
    end
  endtask

  function automatic logic [14:0] exp_vec();
    logic [CW-1:0] c = CW'(m_cnt);
    return {m_valid, m_valid ? m_set[m_pos] : 9'h000,
            m_valid && (m_pos == 0), m_valid && (m_pos == 15), m_valid, c};
  endfunction

  function automatic logic [14:0] obs_vec();
    return {sym_valid_o, sym_valid_o ? {sym_k_o, sym_data_o} : 9'h000,
            sos_o, eos_o, busy_o, os_cnt_o};
  endfunction

  task automatic drain();
    en_i = 1'b0; sym_ready_i = 1'b1;
    for (int i = 0; i < 40 && m_valid; i++) begin
      @(posedge clk_i); model_edge(); #1;
    end
    checks++;
    if (m_valid || sym_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL drain_timeout got_valid=%b required=0", sym_valid_o);
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({sym_valid_o, sym_data_o, sym_k_o, sos_o, eos_o, busy_o, os_cnt_o} !== '0) begin
      failures++;
      $display("FAIL reset_state got=%h required=0",
               {sym_valid_o, sym_data_o, sym_k_o, sos_o, eos_o, busy_o, os_cnt_o});
    end
    @(posedge clk_i); model_edge(); #1;
    rst_ni = 1'b1;
  endtask

  task automatic test_single_ts1();
    logic [8:0] got [$];
    logic [8:0] req [16];
    bit ok;
    req[0] = 9'h1BC; req[1] = 9'h1F7; req[2] = 9'h1F7;
    req[3] = 9'h01F; req[4] = 9'h01E; req[5] = 9'h000;
    for (int i = 6; i < 16; i++) req[i] = 9'h04A;
    ts2_i = 0; link_pad_i = 1; lane_pad_i = 1; n_fts_i = 8'h1F; rate_id_i = 8'h1E;
    train_ctrl_i = 8'h00; link_num_i = 8'h33; lane_num_i = 5'h07; sym_ready_i = 1; en_i = 1;
    for (int i = 0; i < 19; i++) begin
      @(posedge clk_i); model_edge(); #1;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL single_ts1 cyc=%0d got=%h required=%h", cyc, obs_vec(), exp_vec());
      end
      if (sym_valid_o && sym_ready_i) got.push_back({sym_k_o, sym_data_o});
      en_i = 1'b0;
    end
    ok = (got.size() == 16);
    for (int i = 0; i < 16 && ok; i++) if (got[i] !== req[i]) ok = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL single_ts1_seq got_len=%0d required_len=16", got.size());
    end
  endtask

  task automatic test_back_to_back();
    int nvalid = 0;
    ts2_i = 1; link_pad_i = 0; lane_pad_i = 0; link_num_i = 8'h05; lane_num_i = 5'd3;
    n_fts_i = 8'h80; rate_id_i = 8'h06; train_ctrl_i = 8'h00; sym_ready_i = 1; en_i = 1;
    for (int i = 0; i < 48; i++) begin
      @(posedge clk_i); model_edge(); #1;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL back_to_back cyc=%0d got=%h required=%h", cyc, obs_vec(), exp_vec());
      end
      if (sym_valid_o) nvalid++;
      if (i == 46) en_i = 1'b0;
    end
    checks++;
    if (nvalid != 48) begin
      failures++;
      $display("FAIL back_to_back_count got=%0d required=48", nvalid);
    end
    drain();
  endtask

  task automatic test_stall();
    int stall = 0;
    ts2_i = 0; en_i = 1; sym_ready_i = 1;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk_i); model_edge(); #1;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL stall cyc=%0d got=%h required=%h", cyc, obs_vec(), exp_vec());
      end
      en_i = 1'b0;
      if (m_valid && m_pos == 7 && stall < 5) begin sym_ready_i = 1'b0; stall++; end
      else sym_ready_i = 1'b1;
    end
    drain();
  endtask

  task automatic test_midset_change();
    logic [7:0] link_seen [2];
    int set_no = -1;
    link_pad_i = 0; link_num_i = 8'h05; en_i = 1; sym_ready_i = 1;
    for (int i = 0; i < 34; i++) begin
      @(posedge clk_i); model_edge(); #1;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL midset_change cyc=%0d got=%h required=%h", cyc, obs_vec(), exp_vec());
      end
      if (sos_o) set_no++;
      if (m_valid && m_pos == 1 && set_no >= 0 && set_no < 2) link_seen[set_no] = sym_data_o;
      if (m_valid && m_pos == 3) link_num_i = 8'h09;
      if (set_no == 1) en_i = 1'b0;
    end
    checks++;
    if (link_seen[0] !== 8'h05 || link_seen[1] !== 8'h09) begin
      failures++;
      $display("FAIL midset_link got=%h,%h required=05,09", link_seen[0], link_seen[1]);
    end
    drain();
  endtask

  task automatic test_reset_midset();
    en_i = 1; sym_ready_i = 1;
    for (int i = 0; i < 30 && !(m_valid && m_pos == 10); i++) begin
      @(posedge clk_i); model_edge(); #1;
    end
    checks++;
    if (!(m_valid && m_pos == 10) || obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL reach_index10 got=%h required=%h", obs_vec(), exp_vec());
    end
    #2 rst_ni = 1'b0;
    m_valid = 1'b0; m_pos = 0; m_cnt = 0;
    #1;
    checks++;
    if ({sym_valid_o, sym_data_o, sym_k_o, sos_o, eos_o, busy_o, os_cnt_o} !== '0) begin
      failures++;
      $display("FAIL async_reset got=%h required=0",
               {sym_valid_o, sym_data_o, sym_k_o, sos_o, eos_o, busy_o, os_cnt_o});
    end
    @(posedge clk_i); model_edge(); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); model_edge(); #1;
    checks++;
    if (obs_vec() !== exp_vec() || {sym_k_o, sym_data_o} !== 9'h1BC) begin
      failures++;
      $display("FAIL restart_com got=%h required=%h", obs_vec(), exp_vec());
    end
    drain();
  endtask

  task automatic test_count();
    int sets = 0;
    int req;
    rst_ni = 1'b0;
    @(posedge clk_i); model_edge(); #1;
    rst_ni = 1'b1; en_i = 1; sym_ready_i = 1;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk_i); model_edge(); #1;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL count cyc=%0d got=%h required=%h", cyc, obs_vec(), exp_vec());
      end
      if (sos_o) sets++;
      if (sets == 5) en_i = 1'b0;
    end
    drain();
`ifdef PCIE_TS_OS_CNT_EN
    req = CNT_MAX;
`else
    req = 0;
`endif
    checks++;
    if (os_cnt_o !== CW'(req)) begin
      failures++;
      $display("FAIL count_final got=%0d required=%0d", os_cnt_o, req);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk_i); model_edge(); #1;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL random cyc=%0d got=%h required=%h", cyc, obs_vec(), exp_vec());
      end
      en_i         = ($urandom_range(0, 3) != 0);
      sym_ready_i  = ($urandom_range(0, 3) != 0);
      ts2_i        = $urandom_range(0, 1);
      link_pad_i   = $urandom_range(0, 1);
      lane_pad_i   = $urandom_range(0, 1);
      link_num_i   = 8'($urandom);
      lane_num_i   = 5'($urandom);
      n_fts_i      = 8'($urandom);
      rate_id_i    = 8'($urandom);
      train_ctrl_i = 8'($urandom);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single_ts1();
    test_back_to_back();
    test_stall();
    test_midset_change();
    test_reset_midset();
    test_count();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
